input_spike_loader: RTL and testbench

INPUT_SPIKE_LOADER -- requirements
Module: input_spike_loader

---
 rtl/input_spike_loader_pkg.sv | 23 ++
 rtl/spike_word_fifo.sv | 55 +++++
 rtl/input_spike_loader.sv | 165 ++++++++++++++++
 tb/tb_input_spike_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_spike_loader_pkg.sv
// Shared SNN definitions for the spike loader: default widths, neuron/group
// derived SRAM address width, loader FSM states and a small width helper.
package input_spike_loader_pkg;

  localparam int N_SZ       = 32;
  localparam int G_SZ       = 4;
  localparam int SNN_ADDR_W = $clog2(N_SZ * G_SZ);
  localparam int SNN_IN_W   = 16;
  localparam int SNN_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  // Chunk-index width; a one-chunk word still needs a 1-bit index register.
  function automatic int idx_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/spike_word_fifo.sv
// Small staging FIFO between the chunk packer and the SRAM write port.
// Head word is visible combinationally so a pop can register it directly.
module spike_word_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] wdata,
  input  logic              pop,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/input_spike_loader.sv
// Packs external spike chunks LSB-first into SRAM words, stages them in a
// FIFO and writes them to consecutive SRAM addresses whenever the port is granted.
module input_spike_loader
  import input_spike_loader_pkg::*;
#(
  parameter int IN_W        = SNN_IN_W,
  parameter int WORD_W      = SNN_WORD_W,
  parameter int ADDR_W      = SNN_ADDR_W,
  parameter int FRAME_WORDS = 128,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [IN_W-1:0]   ext_in,
  input  logic              ext_valid,
  input  logic              ext_last,
  output logic              ext_ready,
  input  logic              wr_grant,
  output logic [WORD_W-1:0] DIN,
  output logic [ADDR_W-1:0] input_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   words_written
);

  localparam int R     = WORD_W / IN_W;
  localparam int IDX_W = idx_width(R);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(R - 1);
  localparam logic [ADDR_W:0]  FRAME_CNT = (ADDR_W + 1)'(FRAME_WORDS);

  load_state_e       state_q;
  logic [WORD_W-1:0] pack_q;
  logic [IDX_W-1:0]  chunk_idx_q;
  logic [ADDR_W:0]   pushed_q;
  logic              pad_pending_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] din_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_en_q;
  logic              frame_done_q;
  logic [ADDR_W:0]   words_written_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;
  logic              accept;
  logic              word_full;
  logic              pad_push;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] word_asm;
  logic [WORD_W-1:0] push_word;

  // Readiness depends only on registered state, never on wr_grant.
  assign ext_ready = (state_q == ST_LOAD) && !fifo_full;
  assign accept    = ext_ready && ext_valid;
  assign word_full = accept && (chunk_idx_q == LAST_IDX);
  assign pad_push  = (state_q == ST_DRAIN) && pad_pending_q && !fifo_full;
  assign push      = word_full || pad_push;
  assign push_word = pad_push ? pack_q : word_asm;
  assign pop       = !fifo_empty && wr_grant;

  always_comb begin
    word_asm = pack_q;
    word_asm[chunk_idx_q * IN_W +: IN_W] = ext_in;
  end

  spike_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      pack_q          <= '0;
      chunk_idx_q     <= '0;
      pushed_q        <= '0;
      pad_pending_q   <= 1'b0;
      wr_addr_q       <= '0;
      din_q           <= '0;
      addr_q          <= '0;
      wr_en_q         <= 1'b0;
      frame_done_q    <= 1'b0;
      words_written_q <= '0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;

      if (pop) begin
        din_q           <= fifo_rdata;
        addr_q          <= wr_addr_q;
        wr_addr_q       <= wr_addr_q + 1'b1;
        wr_en_q         <= 1'b1;
        words_written_q <= words_written_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q         <= ST_LOAD;
            wr_addr_q       <= base_addr;
            pack_q          <= '0;
            chunk_idx_q     <= '0;
            pushed_q        <= '0;
            pad_pending_q   <= 1'b0;
            words_written_q <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (word_full) begin
              pack_q      <= '0;
              chunk_idx_q <= '0;
              pushed_q    <= pushed_q + 1'b1;
            end else begin
              pack_q      <= word_asm;
              chunk_idx_q <= chunk_idx_q + 1'b1;
            end
          end
          // A partial final word stays in pack_q, zero-padded, until DRAIN pushes it.
          if (accept && ext_last) begin
            state_q       <= ST_DRAIN;
            pad_pending_q <= !word_full;
          end else if (word_full && ((pushed_q + 1'b1) == FRAME_CNT)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pad_push) begin
            pad_pending_q <= 1'b0;
            pack_q        <= '0;
            pushed_q      <= pushed_q + 1'b1;
          end else if (fifo_empty && !pad_pending_q) begin
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign DIN           = din_q;
  assign input_addr    = addr_q;
  assign wr_en         = wr_en_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = frame_done_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_input_spike_loader.sv
// Directed and randomised frames checked against a chunk-list packing model.
module tb_input_spike_loader;

  localparam int IN_W   = 16;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 7;
  localparam int FW     = 4;
  localparam int R      = WORD_W / IN_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [IN_W-1:0]   ext_in = '0;
  logic              ext_valid = 1'b0;
  logic              ext_last = 1'b0;
  logic              ext_ready;
  logic              wr_grant = 1'b1;
  logic [WORD_W-1:0] DIN;
  logic [ADDR_W-1:0] input_addr;
  logic              wr_en;
  logic              busy;
  logic              frame_done;
  logic [ADDR_W:0]   words_written;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int done_pulses = 0;
  logic [WORD_W-1:0] wq_data[$];
  logic [ADDR_W-1:0] wq_addr[$];
  int                wq_cyc[$];
  logic [IN_W-1:0]   chunks[$];

  input_spike_loader #(
    .IN_W        (IN_W),
    .WORD_W      (WORD_W),
    .ADDR_W      (ADDR_W),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .ext_in        (ext_in),
    .ext_valid     (ext_valid),
    .ext_last      (ext_last),
    .ext_ready     (ext_ready),
    .wr_grant      (wr_grant),
    .DIN           (DIN),
    .input_addr    (input_addr),
    .wr_en         (wr_en),
    .busy          (busy),
    .frame_done    (frame_done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_data.push_back(DIN);
      wq_addr.push_back(input_addr);
      wq_cyc.push_back(cyc_cnt);
      $display("write addr=%0d data=%08h cycle=%0d", input_addr, DIN, cyc_cnt);
    end
    if (frame_done === 1'b1) done_pulses <= done_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stall_chk(input string tag, input int acc, input int n_acc);
    chk({tag, " acc_at_stall_end"}, 64'(acc), 64'(n_acc));
    chk({tag, " ready_low_stalled"}, 64'(ext_ready), 64'd0);
    chk({tag, " no_write_stalled"}, 64'(wq_data.size()), 64'd0);
  endtask

  // Expected frame: first min(n, R*FW) chunks, packed R per word LSB-first,
  // last word zero-padded, written at base, base+1, ... modulo 2^ADDR_W.
  task automatic run_frame(input string tag, input logic use_last,
                           input logic [ADDR_W-1:0] base, input int stall);
    int n, n_acc, nw, idx, cyc, w, done0, hs;
    logic acc;
    logic [WORD_W-1:0] exp_word;
    logic [ADDR_W-1:0] exp_addr;
    logic [IN_W-1:0]   hi;
    n     = chunks.size();
    n_acc = (n < R * FW) ? n : R * FW;
    nw    = (n_acc + R - 1) / R;
    wq_data.delete();
    wq_addr.delete();
    wq_cyc.delete();
    done0 = done_pulses;
    hs    = -1;
    base_addr = base;
    wr_grant  = (stall == 0);
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 400 && done_pulses == done0) begin
      if (stall >= 12 && cyc == stall) stall_chk(tag, idx, n_acc);
      wr_grant  = (cyc >= stall);
      ext_valid = 1'b1;
      ext_in    = chunks[idx];
      ext_last  = use_last && (idx == n - 1);
      acc       = ext_ready;
      if (acc === 1'b1 && (idx % R) == R - 1 && hs < 0) hs = cyc_cnt;
      step();
      cyc++;
      if (acc === 1'b1) idx++;
    end
    ext_valid = 1'b0;
    ext_last  = 1'b0;
    ext_in    = '0;
    while (cyc < stall) begin
      wr_grant = 1'b0;
      step();
      cyc++;
    end
    if (stall >= 12 && cyc == stall) stall_chk(tag, idx, n_acc);
    wr_grant = 1'b1;
    w = 0;
    while (done_pulses == done0 && w < 200) begin
      step();
      w++;
    end
    step();
    step();
    chk({tag, " accepted"}, 64'(idx), 64'(n_acc));
    chk({tag, " done_pulses"}, 64'(done_pulses - done0), 64'd1);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " words_written"}, 64'(words_written), 64'(nw));
    chk({tag, " write_count"}, 64'(wq_data.size()), 64'(nw));
    for (int i = 0; i < nw && i < wq_data.size(); i++) begin
      hi       = (R * i + 1 < n_acc) ? chunks[R * i + 1] : '0;
      exp_word = {hi, chunks[R * i]};
      exp_addr = base + ADDR_W'(i);
      chk($sformatf("%s data[%0d]", tag, i), 64'(wq_data[i]), 64'(exp_word));
      chk($sformatf("%s addr[%0d]", tag, i), 64'(wq_addr[i]), 64'(exp_addr));
    end
    if (stall == 0 && hs >= 0 && wq_cyc.size() > 0)
      chk({tag, " latency"}, 64'(wq_cyc[0] - hs), 64'd2);
    $display("frame %s chunks=%0d accepted=%0d writes=%0d", tag, n, idx, wq_data.size());
  endtask

  initial begin
    int n, cyc, idx;
    logic acc;

    // Reset state
    step();
    step();
    chk("rst DIN", 64'(DIN), 64'd0);
    chk("rst addr", 64'(input_addr), 64'd0);
    chk("rst wr_en", 64'(wr_en), 64'd0);
    chk("rst ready", 64'(ext_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(frame_done), 64'd0);
    chk("rst words", 64'(words_written), 64'd0);
    rst = 1'b1;
    step();

    // Full final word with last
    chunks = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_frame("basic", 1'b1, 7'd8, 0);
    if (wq_data.size() > 1) begin
      chk("basic const w0", 64'(wq_data[0]), 64'h0002_0001);
      chk("basic const w1", 64'(wq_data[1]), 64'h0004_0003);
      chk("basic const a1", 64'(wq_addr[1]), 64'd9);
    end

    // Partial final word is zero padded
    chunks = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_frame("pad", 1'b1, 7'd20, 0);
    if (wq_data.size() > 1)
      chk("pad const w1", 64'(wq_data[1]), 64'h0000_CCCC);

    // Frame capped at FRAME_WORDS without last
    chunks = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505,
               16'h0606, 16'h0707, 16'h0808, 16'h0909, 16'h0A0A};
    run_frame("cap", 1'b0, 7'd40, 0);

    // Write port withheld: FIFO fills, then drains in order
    chunks = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005,
               16'h1006, 16'h1007, 16'h1008, 16'h1009, 16'h100A};
    run_frame("stall", 1'b0, 7'd60, 20);

    // Address wrap at top of SRAM
    chunks = '{16'h00A1, 16'h00A2, 16'h00B1, 16'h00B2, 16'h00C1, 16'h00C2};
    run_frame("wrap", 1'b1, 7'd126, 0);
    if (wq_addr.size() > 2) begin
      chk("wrap a0", 64'(wq_addr[0]), 64'd126);
      chk("wrap a2", 64'(wq_addr[2]), 64'd0);
    end

    // Reset mid-frame after three chunks
    chunks = '{16'h1111, 16'h2222, 16'h3333};
    base_addr = 7'd5;
    wr_grant = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 50) begin
      ext_valid = 1'b1;
      ext_in = chunks[idx];
      acc = ext_ready;
      step();
      cyc++;
      if (acc === 1'b1) idx++;
    end
    ext_valid = 1'b0;
    rst = 1'b0;
    wq_data.delete();
    wq_addr.delete();
    wq_cyc.delete();
    step();
    chk("midrst DIN", 64'(DIN), 64'd0);
    chk("midrst addr", 64'(input_addr), 64'd0);
    chk("midrst wr_en", 64'(wr_en), 64'd0);
    chk("midrst ready", 64'(ext_ready), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(frame_done), 64'd0);
    chk("midrst words", 64'(words_written), 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("midrst no_write", 64'(wq_data.size()), 64'd0);
    $display("reset mid-frame accepted=%0d", idx);

    chunks = '{16'h7E01, 16'h7E02, 16'h7E03};
    run_frame("after_rst", 1'b1, 7'd90, 0);

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      logic ul;
      n = $urandom_range(1, 10);
      ul = (n < R * FW) ? 1'b1 : 1'($urandom_range(0, 1));
      chunks.delete();
      for (int k = 0; k < n; k++) chunks.push_back(IN_W'($urandom));
      run_frame($sformatf("rand%0d", f), ul, ADDR_W'($urandom), $urandom_range(0, 14));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
